// File: rtl/rvfi_commit_tracker_if.sv
// rtl/rvfi_commit_tracker_if.sv - ROB retire bus between the out-of-order core and the commit tracker
interface rvfi_commit_tracker_if #(
    parameter int NUM_CH = 2,
    parameter int TAG_W  = 3
);
    logic [NUM_CH-1:0]       commit_valid;
    logic [NUM_CH*TAG_W-1:0] commit_tag;
    logic [NUM_CH*32-1:0]    commit_inst;
    logic [NUM_CH*32-1:0]    commit_pc_rdata;
    logic [NUM_CH*32-1:0]    commit_pc_wdata;
    logic [NUM_CH*5-1:0]     commit_rs1_addr;
    logic [NUM_CH*5-1:0]     commit_rs2_addr;
    logic [NUM_CH*5-1:0]     commit_rd_addr;
    logic [NUM_CH*32-1:0]    commit_rs1_rdata;
    logic [NUM_CH*32-1:0]    commit_rs2_rdata;
    logic [NUM_CH*32-1:0]    commit_rd_wdata;
    logic [NUM_CH-1:0]       commit_imm;
    logic [NUM_CH-1:0]       commit_load_rf;
    logic                    commit_ready;

    modport master (
        output commit_valid, commit_tag, commit_inst, commit_pc_rdata, commit_pc_wdata,
               commit_rs1_addr, commit_rs2_addr, commit_rd_addr,
               commit_rs1_rdata, commit_rs2_rdata, commit_rd_wdata,
               commit_imm, commit_load_rf,
        input  commit_ready
    );

    modport slave (
        input  commit_valid, commit_tag, commit_inst, commit_pc_rdata, commit_pc_wdata,
               commit_rs1_addr, commit_rs2_addr, commit_rd_addr,
               commit_rs1_rdata, commit_rs2_rdata, commit_rd_wdata,
               commit_imm, commit_load_rf,
        output commit_ready
    );
endinterface

// File: rtl/rvfi_commit_tracker.sv
// rtl/rvfi_commit_tracker.sv - multi-channel retire to single-channel RVFI serialiser with PC correction
module rvfi_commit_tracker #(
    parameter int NUM_CH     = 2,
    parameter int ROB_DEPTH  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    rvfi_commit_tracker_if.slave         commit,
    input  logic                         resolve_valid,
    input  logic [$clog2(ROB_DEPTH)-1:0] resolve_tag,
    input  logic [31:0]                  resolve_pc,
    input  logic                         flush,
    output logic                         rvfi_valid,
    output logic [63:0]                  rvfi_order,
    output logic                         rvfi_halt,
    output logic [31:0]                  rvfi_inst,
    output logic [31:0]                  rvfi_pc_rdata,
    output logic [31:0]                  rvfi_pc_wdata,
    output logic [31:0]                  rvfi_rs1_rdata,
    output logic [31:0]                  rvfi_rs2_rdata,
    output logic [31:0]                  rvfi_rd_wdata,
    output logic [4:0]                   rvfi_rs1_addr,
    output logic [4:0]                   rvfi_rs2_addr,
    output logic [4:0]                   rvfi_rd_addr,
    output logic                         rvfi_load_regfile,
    output logic                         overflow_err
);
    localparam int TAG_W = $clog2(ROB_DEPTH);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NC_W  = $clog2(NUM_CH + 1);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [31:0] rd_wdata;
        logic        load_rf;
    } pkt_t;

    pkt_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [ROB_DEPTH-1:0] tbl_valid;
    logic [31:0]      tbl_pc [ROB_DEPTH];
    logic             halted;
    logic             ready_q;
    logic [63:0]      order_cnt;

    logic             res_ok;
    pkt_t             new_pkt [NUM_CH];
    pkt_t             enq_pkt [NUM_CH];
    logic [NC_W-1:0]  new_cnt;
    logic [NC_W-1:0]  enq_cnt;
    logic [ROB_DEPTH-1:0] clr_mask;
    logic [ROB_DEPTH-1:0] tbl_valid_next;
    logic             from_fifo;
    logic             emit;
    pkt_t             out_pkt;
    logic [CNT_W-1:0] count_next;
    logic             halt_hit;

    assign commit.commit_ready = ready_q & rst;
    // Flush beats a same-cycle resolve, including its bypass path.
    assign res_ok = resolve_valid & ~flush;

    always_comb begin
        pkt_t p;
        logic [TAG_W-1:0] tag;
        int n;
        p        = '0;
        tag      = '0;
        n        = 0;
        clr_mask = '0;
        for (int i = 0; i < NUM_CH; i++) new_pkt[i] = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            tag        = commit.commit_tag[i*TAG_W +: TAG_W];
            p.inst     = commit.commit_inst[i*32 +: 32];
            p.pc_rdata = commit.commit_pc_rdata[i*32 +: 32];
            if (res_ok && resolve_tag == tag)  p.pc_wdata = resolve_pc;
            else if (tbl_valid[tag])           p.pc_wdata = tbl_pc[tag];
            else                               p.pc_wdata = commit.commit_pc_wdata[i*32 +: 32];
            p.rs1_addr  = commit.commit_rs1_addr[i*5 +: 5];
            p.rs1_rdata = commit.commit_rs1_rdata[i*32 +: 32];
            p.rs2_addr  = commit.commit_imm[i] ? 5'd0  : commit.commit_rs2_addr[i*5 +: 5];
            p.rs2_rdata = commit.commit_imm[i] ? 32'd0 : commit.commit_rs2_rdata[i*32 +: 32];
            p.rd_addr   = commit.commit_rd_addr[i*5 +: 5];
            p.rd_wdata  = (p.rd_addr == 5'd0) ? 32'd0 : commit.commit_rd_wdata[i*32 +: 32];
            p.load_rf   = commit.commit_load_rf[i];
            if (commit.commit_ready && commit.commit_valid[i]) begin
                new_pkt[n]    = p;
                n             = n + 1;
                clr_mask[tag] = 1'b1;
            end
        end
        new_cnt = NC_W'(n);
    end

    // With an empty FIFO the oldest new packet bypasses straight to the output.
    always_comb begin
        from_fifo = (count != '0);
        emit      = from_fifo || (new_cnt != '0);
        out_pkt   = from_fifo ? mem[rd_ptr] : new_pkt[0];
        for (int j = 0; j < NUM_CH; j++)
            enq_pkt[j] = from_fifo ? new_pkt[j] : new_pkt[(j + 1) % NUM_CH];
        enq_cnt    = (from_fifo || new_cnt == '0) ? new_cnt : new_cnt - NC_W'(1);
        count_next = count + CNT_W'(enq_cnt) - CNT_W'(from_fifo);
        halt_hit   = emit && (out_pkt.inst == 32'h0000_0063 || out_pkt.inst == 32'h0000_006f);
        tbl_valid_next = tbl_valid;
        if (res_ok) tbl_valid_next[resolve_tag] = 1'b1;
        tbl_valid_next = tbl_valid_next & ~clr_mask;
        if (flush) tbl_valid_next = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < NUM_CH; j++)
                if (NC_W'(j) < enq_cnt) mem[wr_ptr + PTR_W'(j)] <= enq_pkt[j];
            if (res_ok) tbl_pc[resolve_tag] <= resolve_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            tbl_valid         <= '0;
            halted            <= 1'b0;
            ready_q           <= 1'b1;
            order_cnt         <= '0;
            overflow_err      <= 1'b0;
            rvfi_valid        <= 1'b0;
            rvfi_order        <= '0;
            rvfi_halt         <= 1'b0;
            rvfi_inst         <= '0;
            rvfi_pc_rdata     <= '0;
            rvfi_pc_wdata     <= '0;
            rvfi_rs1_rdata    <= '0;
            rvfi_rs2_rdata    <= '0;
            rvfi_rd_wdata     <= '0;
            rvfi_rs1_addr     <= '0;
            rvfi_rs2_addr     <= '0;
            rvfi_rd_addr      <= '0;
            rvfi_load_regfile <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr + PTR_W'(enq_cnt);
            if (from_fifo) rd_ptr <= rd_ptr + PTR_W'(1);
            count     <= count_next;
            tbl_valid <= tbl_valid_next;
            halted    <= halted | halt_hit;
            ready_q   <= (count_next <= CNT_W'(FIFO_DEPTH - NUM_CH)) && !(halted || halt_hit);
            if ((|commit.commit_valid) && !ready_q) overflow_err <= 1'b1;
            rvfi_valid <= emit;
            rvfi_halt  <= halt_hit;
            if (emit) begin
                order_cnt         <= order_cnt + 64'd1;
                rvfi_order        <= order_cnt;
                rvfi_inst         <= out_pkt.inst;
                rvfi_pc_rdata     <= out_pkt.pc_rdata;
                rvfi_pc_wdata     <= out_pkt.pc_wdata;
                rvfi_rs1_rdata    <= out_pkt.rs1_rdata;
                rvfi_rs2_rdata    <= out_pkt.rs2_rdata;
                rvfi_rd_wdata     <= out_pkt.rd_wdata;
                rvfi_rs1_addr     <= out_pkt.rs1_addr;
                rvfi_rs2_addr     <= out_pkt.rs2_addr;
                rvfi_rd_addr      <= out_pkt.rd_addr;
                rvfi_load_regfile <= out_pkt.load_rf;
            end
        end
    end
endmodule
